// File: rtl/axi_lite_arbiter_2m_if.sv
// axi_lite_if: AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter_2m.sv
// axi_lite_arbiter_2m: shares one AXI4-Lite master port between two requesters, one transaction in flight.
// Round-robin by default; define ARB_FIXED_PRIO_EN to make S0 always win simultaneous requests.
module axi_lite_arbiter_2m #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       nrst,
    axi_lite_if.slave  s0,
    axi_lite_if.slave  s1,
    axi_lite_if.master m,
    output logic [1:0] grant,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_A, RD_D} state_t;
    state_t state;
    logic aw_done, w_done;
    logic req0, req1, pick1, own1, wa, wb, ra, rd;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [ADDR_WIDTH-1:0]   src_awaddr, src_araddr;
    logic [DATA_WIDTH-1:0]   src_wdata;
    logic [DATA_WIDTH/8-1:0] src_wstrb;
    assign req0  = s0.awvalid | s0.arvalid;
    assign req1  = s1.awvalid | s1.arvalid;
    assign own1  = grant[1];
    assign wa    = state == WR_A;
    assign wb    = state == WR_B;
    assign ra    = state == RD_A;
    assign rd    = state == RD_D;
    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid & m.wready;
    assign b_hs  = m.bvalid & m.bready;
    assign ar_hs = m.arvalid & m.arready;
    assign r_hs  = m.rvalid & m.rready;
`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = ~req0;
`else
    logic rr_last;
    assign pick1 = req1 & (~req0 | ~rr_last);
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) rr_last <= 1'b1;
        else rr_last <= (b_hs | r_hs) ? grant[1] : rr_last;
`endif
    // Forwarding is purely combinational; everything is gated to zero outside the owning phase.
    always_comb begin
        src_awaddr = own1 ? s1.awaddr : s0.awaddr;
        src_araddr = own1 ? s1.araddr : s0.araddr;
        src_wdata  = own1 ? s1.wdata  : s0.wdata;
        src_wstrb  = own1 ? s1.wstrb  : s0.wstrb;
        m.awaddr   = wa ? src_awaddr : '0;
        m.awprot   = wa ? (own1 ? s1.awprot : s0.awprot) : '0;
        m.awvalid  = wa & ~aw_done & (own1 ? s1.awvalid : s0.awvalid);
        m.wdata    = wa ? src_wdata : '0;
        m.wstrb    = wa ? src_wstrb : '0;
        m.wvalid   = wa & ~w_done & (own1 ? s1.wvalid : s0.wvalid);
        m.bready   = wb & (own1 ? s1.bready : s0.bready);
        m.araddr   = ra ? src_araddr : '0;
        m.arprot   = ra ? (own1 ? s1.arprot : s0.arprot) : '0;
        m.arvalid  = ra & (own1 ? s1.arvalid : s0.arvalid);
        m.rready   = rd & (own1 ? s1.rready : s0.rready);
        s0.awready = wa & ~own1 & ~aw_done & m.awready;
        s0.wready  = wa & ~own1 & ~w_done & m.wready;
        s0.bvalid  = wb & ~own1 & m.bvalid;
        s0.bresp   = (wb & ~own1) ? m.bresp : '0;
        s0.arready = ra & ~own1 & m.arready;
        s0.rvalid  = rd & ~own1 & m.rvalid;
        s0.rdata   = (rd & ~own1) ? m.rdata : '0;
        s0.rresp   = (rd & ~own1) ? m.rresp : '0;
        s1.awready = wa & own1 & ~aw_done & m.awready;
        s1.wready  = wa & own1 & ~w_done & m.wready;
        s1.bvalid  = wb & own1 & m.bvalid;
        s1.bresp   = (wb & own1) ? m.bresp : '0;
        s1.arready = ra & own1 & m.arready;
        s1.rvalid  = rd & own1 & m.rvalid;
        s1.rdata   = (rd & own1) ? m.rdata : '0;
        s1.rresp   = (rd & own1) ? m.rresp : '0;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    grant <= pick1 ? 2'b10 : 2'b01;
                    busy  <= 1'b1;
                    state <= (pick1 ? s1.awvalid : s0.awvalid) ? WR_A : RD_A;
                end
                WR_A: if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    state   <= WR_B;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                end
                WR_B: if (b_hs) begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                RD_A: if (ar_hs) state <= RD_D;
                RD_D: if (r_hs) begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter_2m.sv
// tb_axi_lite_arbiter_2m: directed and randomized checks of the two-requester AXI4-Lite arbiter
// against a memory/arbitration reference model; honours ARB_FIXED_PRIO_EN like the design.
module tb_axi_lite_arbiter_2m;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0, nrst = 1'b0;
    always #5 clk = ~clk;
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s [2] ();
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();
    logic [1:0] grant;
    logic       busy;
    axi_lite_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .s0(s[0]), .s1(s[1]), .m(m), .grant(grant), .busy(busy)
    );
    logic [31:0] awaddr [2], wdata [2], araddr [2];
    logic [3:0]  wstrb [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    logic [1:0]  o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp [2], o_rresp [2];
    logic [31:0] o_rdata [2];
    for (genvar g = 0; g < 2; g++) begin : g_m
        assign s[g].awaddr  = awaddr[g];
        assign s[g].awprot  = awprot[g];
        assign s[g].awvalid = awvalid[g];
        assign s[g].wdata   = wdata[g];
        assign s[g].wstrb   = wstrb[g];
        assign s[g].wvalid  = wvalid[g];
        assign s[g].bready  = bready[g];
        assign s[g].araddr  = araddr[g];
        assign s[g].arprot  = arprot[g];
        assign s[g].arvalid = arvalid[g];
        assign s[g].rready  = rready[g];
        assign o_awready[g] = s[g].awready;
        assign o_wready[g]  = s[g].wready;
        assign o_bvalid[g]  = s[g].bvalid;
        assign o_bresp[g]   = s[g].bresp;
        assign o_arready[g] = s[g].arready;
        assign o_rvalid[g]  = s[g].rvalid;
        assign o_rdata[g]   = s[g].rdata;
        assign o_rresp[g]   = s[g].rresp;
    end
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // Environment rules shared by the slave model and the expectations.
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[11:8] == 4'hE ? 2'b10 : a[11:8] == 4'hD ? 2'b11 : 2'b00;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : a ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : a ^ 32'hA5A5_0000;
    endfunction
    function automatic logic outs_or();
        return |{m.awvalid, m.wvalid, m.arvalid, m.bready, m.rready, m.awaddr, m.awprot, m.wdata,
                 m.wstrb, m.araddr, m.arprot, o_awready, o_wready, o_bvalid, o_arready, o_rvalid,
                 o_bresp[0], o_bresp[1], o_rresp[0], o_rresp[1], o_rdata[0], o_rdata[1], grant, busy};
    endfunction
    function automatic logic side_or(input int n);
        return |{o_awready[n], o_wready[n], o_bvalid[n], o_bresp[n], o_arready[n], o_rvalid[n],
                 o_rdata[n], o_rresp[n]};
    endfunction
    // Crossbar-side slave model: configurable ready/response delays, byte-strobed memory.
    int w_dly = 0, r_dly = 0;
    bit rnd = 1'b0;
    initial begin
        logic aw_h, w_h, b_h, ar_h, r_h, have_aw, have_w, b_pend, r_pend;
        logic [31:0] aw_a, w_d, ar_a, wa_q, wd_q, ra_q;
        logic [3:0] w_s, ws_q;
        logic [1:0] br_q;
        int b_c, r_c, w_c;
        {have_aw, have_w, b_pend, r_pend} = '0;
        w_c = 0; b_c = 0; r_c = 0;
        {m.awready, m.wready, m.bvalid, m.bresp, m.arready, m.rvalid, m.rdata, m.rresp} = '0;
        forever begin
            @(negedge clk);
            aw_h = m.awvalid & m.awready; aw_a = m.awaddr;
            w_h = m.wvalid & m.wready; w_d = m.wdata; w_s = m.wstrb;
            b_h = m.bvalid & m.bready;
            ar_h = m.arvalid & m.arready; ar_a = m.araddr;
            r_h = m.rvalid & m.rready;
            @(posedge clk); #1;
            if (!nrst) begin
                {m.awready, m.wready, m.bvalid, m.bresp, m.arready, m.rvalid, m.rdata, m.rresp} = '0;
                {have_aw, have_w, b_pend, r_pend} = '0;
                w_c = 0;
            end else begin
                if (aw_h) begin have_aw = 1'b1; wa_q = aw_a; end
                if (w_h) begin have_w = 1'b1; wd_q = w_d; ws_q = w_s; end
                if (have_aw && have_w) begin
                    smem[wa_q] = merge(smem_rd(wa_q), wd_q, ws_q);
                    {have_aw, have_w} = '0;
                    b_pend = 1'b1; b_c = rnd ? $urandom_range(0, 3) : 0; br_q = resp_of(wa_q);
                end
                if (b_h) begin m.bvalid = 1'b0; m.bresp = '0; end
                if (b_pend) begin
                    if (b_c == 0) begin m.bvalid = 1'b1; m.bresp = br_q; b_pend = 1'b0; end else b_c--;
                end
                if (ar_h) begin r_pend = 1'b1; r_c = rnd ? $urandom_range(0, 3) : r_dly; ra_q = ar_a; end
                if (r_h) begin m.rvalid = 1'b0; m.rdata = '0; m.rresp = '0; end
                if (r_pend) begin
                    if (r_c == 0) begin
                        m.rvalid = 1'b1; m.rdata = smem_rd(ra_q); m.rresp = resp_of(ra_q); r_pend = 1'b0;
                    end else r_c--;
                end
                m.awready = m.awvalid & ~aw_h & (rnd ? $urandom_range(0, 2) != 0 : 1'b1);
                m.arready = m.arvalid & ~ar_h & (rnd ? $urandom_range(0, 2) != 0 : 1'b1);
                if (w_h || !m.wvalid) begin m.wready = 1'b0; w_c = 0; end
                else begin m.wready = rnd ? $urandom_range(0, 2) != 0 : w_c >= w_dly; w_c++; end
            end
        end
    end
    // Bus monitor: handshake counts, grant log, per-cycle ownership and pass-through rules.
    int cyc = 0, hs_aw = 0, hs_w = 0, t_aw = 0, t_w = 0, rv0 = 0;
    logic [1:0] g_acc = '0;
    logic busy_q = 1'b0;
    int glog [$];
    always @(negedge clk) begin
        int g;
        cyc++;
        g = grant[1] ? 1 : 0;
        if (m.awvalid & m.awready) begin hs_aw++; t_aw = cyc; end
        if (m.wvalid & m.wready) begin hs_w++; t_w = cyc; end
        if (o_rvalid[0]) rv0++;
        if (busy && !busy_q) begin glog.push_back(g * 2 + (m.awvalid ? 1 : 0)); g_acc = grant; end
        else if (busy) g_acc |= grant;
        busy_q = busy;
        chk("busy_vs_grant", {grant == 2'b11, busy}, {1'b0, grant != 2'b00});
        for (int n = 0; n < 2; n++) if (!grant[n]) chk("unowned_quiet", side_or(n), 0);
        if (m.awvalid) chk("fwd_aw", {m.awprot, m.awaddr}, {awprot[g], awaddr[g]});
        if (m.wvalid) chk("fwd_w", {m.wstrb, m.wdata}, {wstrb[g], wdata[g]});
        if (m.arvalid) chk("fwd_ar", {m.arprot, m.araddr}, {arprot[g], araddr[g]});
        if (busy && o_rvalid[g]) chk("fwd_r", {o_rresp[g], o_rdata[g]}, {m.rresp, m.rdata});
        if (busy && o_bvalid[g]) chk("fwd_b", o_bresp[g], m.bresp);
    end
    task automatic wr(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [1:0] resp);
        int t = 0;
        logic ah, wh, bh;
        resp = 'x;
        awaddr[n] = a; awprot[n] = 3'(n + 2); wdata[n] = d; wstrb[n] = st;
        awvalid[n] = 1'b1; wvalid[n] = 1'b1;
        while ((awvalid[n] | wvalid[n]) && t < 200) begin
            @(negedge clk); ah = awvalid[n] & o_awready[n]; wh = wvalid[n] & o_wready[n];
            @(posedge clk); #1; t++;
            if (ah) begin awvalid[n] = 1'b0; awaddr[n] = '0; end
            if (wh) begin wvalid[n] = 1'b0; wdata[n] = '0; wstrb[n] = '0; end
        end
        bready[n] = 1'b1;
        while (bready[n] && t < 200) begin
            @(negedge clk); bh = o_bvalid[n]; if (bh) resp = o_bresp[n];
            @(posedge clk); #1; t++;
            if (bh) bready[n] = 1'b0;
        end
        chk("wr_done_in_time", t < 200, 1);
        {awvalid[n], wvalid[n], bready[n]} = '0;
    endtask
    task automatic rd(input int n, input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        logic ah, rh;
        d = 'x; resp = 'x;
        araddr[n] = a; arprot[n] = 3'(n + 5); arvalid[n] = 1'b1;
        while (arvalid[n] && t < 200) begin
            @(negedge clk); ah = o_arready[n];
            @(posedge clk); #1; t++;
            if (ah) begin arvalid[n] = 1'b0; araddr[n] = '0; end
        end
        rready[n] = 1'b1;
        while (rready[n] && t < 200) begin
            @(negedge clk); rh = o_rvalid[n]; if (rh) begin d = o_rdata[n]; resp = o_rresp[n]; end
            @(posedge clk); #1; t++;
            if (rh) rready[n] = 1'b0;
        end
        chk("rd_done_in_time", t < 200, 1);
        {arvalid[n], rready[n]} = '0;
    endtask
    task automatic rnd_master(input int n);
        logic [31:0] a, d;
        logic [3:0] st;
        logic [1:0] resp;
        for (int i = 0; i < 20; i++) begin
            a = {20'h0, n == 1 ? ($urandom_range(0, 1) ? 4'hE : 4'h1) : ($urandom_range(0, 1) ? 4'hD : 4'h0),
                 2'b00, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; st = 4'($urandom_range(1, 15));
                wr(n, a, d, st, resp);
                chk("rnd_bresp", resp, resp_of(a));
                rmem[a] = merge(ref_rd(a), d, st);
            end else begin
                rd(n, a, d, resp);
                chk("rnd_rdata", d, ref_rd(a));
                chk("rnd_rresp", resp, resp_of(a));
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
    initial begin
        logic [31:0] d, d2;
        logic [1:0] resp, resp2;
        int base, a0, w0, r0, rem [2], last, pick;
        logic pend;
        for (int n = 0; n < 2; n++) begin
            awaddr[n] = '0; wdata[n] = '0; araddr[n] = '0; wstrb[n] = '0; awprot[n] = '0; arprot[n] = '0;
        end
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        repeat (3) @(negedge clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_outputs", outs_or(), 0);
        @(posedge clk); #1; nrst = 1'b1;
        @(posedge clk); #1;
        // Write with awready one cycle ahead of wready.
        w_dly = 1; a0 = hs_aw; w0 = hs_w;
        wr(0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, resp);
        rmem[32'h4] = 32'hDEAD_BEEF;
        w_dly = 0;
        chk("t1_bresp", resp, 2'b00);
        chk("t1_aw_hs", hs_aw - a0, 1);
        chk("t1_w_hs", hs_w - w0, 1);
        chk("t1_aw_before_w", t_w - t_aw, 1);
        chk("t1_grant", g_acc, 2'b01);
        chk("t1_mem", smem_rd(32'h4), 32'hDEAD_BEEF);
        // S1 read with a slow slave.
        smem[32'h1008] = 32'h1234_5678; r_dly = 3; r0 = rv0;
        rd(1, 32'h0000_1008, d, resp);
        chk("t2_busy_drop", busy, 1'b0);
        chk("t2_rdata", d, 32'h1234_5678);
        chk("t2_rresp", resp, 2'b00);
        chk("t2_s0_no_rvalid", rv0 - r0, 0);
        chk("t2_grant", g_acc, 2'b10);
        r_dly = 0;
        // Simultaneous continuous reads from both requesters.
        base = glog.size();
        fork
            for (int i = 0; i < 4; i++) begin
                logic [31:0] x; logic [1:0] xr;
                rd(0, 32'h0000_0008, x, xr); chk("t3_s0_rdata", x, ref_rd(32'h8));
            end
            for (int i = 0; i < 4; i++) begin
                logic [31:0] x; logic [1:0] xr;
                rd(1, 32'h0000_0108, x, xr); chk("t3_s1_rdata", x, ref_rd(32'h108));
            end
        join
        chk("t3_grant_count", glog.size() - base, 8);
        rem[0] = 4; rem[1] = 4; last = 1;
        for (int k = 0; k < 8; k++) begin
            pick = (rem[0] > 0 && rem[1] > 0) ? (FIXED ? 0 : 1 - last) : (rem[0] > 0 ? 0 : 1);
            rem[pick]--; last = pick;
            if (base + k < glog.size()) chk("t3_order", glog[base + k] / 2, pick);
        end
        // Write and read pending together on S0: write goes first.
        base = glog.size();
        fork
            wr(0, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, resp);
            rd(0, 32'h0000_0020, d, resp2);
        join
        rmem[32'h20] = 32'hCAFE_F00D;
        chk("t4_count", glog.size() - base, 2);
        if (glog.size() - base >= 2) begin
            chk("t4_first_write", glog[base], 1);
            chk("t4_then_read", glog[base + 1], 0);
        end
        chk("t4_rdata", d, 32'hCAFE_F00D);
        chk("t4_bresp", resp, 2'b00);
        // Reset while the read data phase is stalled.
        r_dly = 2; araddr[0] = 32'h30; arprot[0] = 3'd5; arvalid[0] = 1'b1; pend = 1'b0;
        for (int i = 0; i < 50 && !pend; i++) begin
            logic ah;
            @(negedge clk); ah = o_arready[0] & arvalid[0]; pend = m.rvalid & busy & o_rvalid[0];
            if (!pend) begin @(posedge clk); #1; if (ah) begin arvalid[0] = 1'b0; araddr[0] = '0; end end
        end
        chk("t5_rd_d_pending", pend, 1'b1);
        @(posedge clk); #1;
        nrst = 1'b0; arvalid[0] = 1'b0; araddr[0] = '0; arprot[0] = '0;
        #1;
        chk("t5_async_outputs", outs_or(), 0);
        @(negedge clk);
        chk("t5_idle_grant", grant, 2'b00);
        chk("t5_idle_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1; nrst = 1'b1; r_dly = 0;
        @(posedge clk); #1;
        rd(0, 32'h0000_0030, d, resp);
        chk("t5_rdata_after", d, ref_rd(32'h30));
        // Error response passes through unmodified; S0 then granted.
        wr(1, 32'h0000_0E00, 32'h0BAD_F00D, 4'h3, resp);
        rmem[32'hE00] = merge(ref_rd(32'hE00), 32'h0BAD_F00D, 4'h3);
        chk("t6_bresp", resp, 2'b10);
        base = glog.size();
        rd(0, 32'h0000_0004, d, resp);
        chk("t6_s0_grant", glog.size() > base ? glog[base] : -1, 0);
        chk("t6_rdata", d, 32'hDEAD_BEEF);
        // Randomized concurrent traffic on disjoint address regions.
        rnd = 1'b1;
        fork
            rnd_master(0);
            rnd_master(1);
        join
        rnd = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
